usb_rx_fifo_ctrl: RTL and testbench

//  Sequences the USB 1.1 RX byte FIFO (fifo_rx, depth 2). Frames packets between

---
 rtl/usb_rx_fifo_ctrl_if.sv | 45 ++++
 rtl/usb_rx_fifo_ctrl.sv | 131 +++++++++++++
 tb/tb_usb_rx_fifo_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_fifo_ctrl_if
// Description : Handshake bundle between the USB RX decoder / consumer side
//               (master) and the RX FIFO sequencing controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_rx_fifo_ctrl_if #(
    parameter int DEPTH     = 2,
    parameter int MAX_BYTES = 64
);
    // Decoder-side events and consumer read request
    logic                           sync_detect;
    logic                           byte_ready;
    logic                           eop;
    logic                           stuff_err;
    logic                           rd_req;

    // FIFO strobes and status
    logic                           w_en;
    logic                           r_en;
    logic                           rd_valid;
    logic [$clog2(DEPTH+1)-1:0]     occupancy;
    logic                           fifo_empty;
    logic                           fifo_full;
    logic [$clog2(MAX_BYTES+1)-1:0] pkt_len;
    logic                           rx_busy;
    logic                           rx_done;
    logic                           rx_error;

    // Decoder / consumer side
    modport master (
        output sync_detect, byte_ready, eop, stuff_err, rd_req,
        input  w_en, r_en, rd_valid, occupancy, fifo_empty, fifo_full,
               pkt_len, rx_busy, rx_done, rx_error
    );

    // Controller side
    modport slave (
        input  sync_detect, byte_ready, eop, stuff_err, rd_req,
        output w_en, r_en, rd_valid, occupancy, fifo_empty, fifo_full,
               pkt_len, rx_busy, rx_done, rx_error
    );
endinterface
`default_nettype wire

// File: rtl/usb_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_fifo_ctrl
// Description : Sequencer for the USB 1.1 RX byte FIFO. Frames packets between
//               SYNC and EOP, generates FIFO write/read strobes, tracks
//               occupancy and packet length, flags overflow, bit-stuff and
//               over-length errors.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_fifo_ctrl #(
    parameter int DEPTH     = 2,
    parameter int MAX_BYTES = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    usb_rx_fifo_ctrl_if.slave bus
);

    localparam int c_OCC_W = $clog2(DEPTH + 1);
    localparam int c_LEN_W = $clog2(MAX_BYTES + 1);

    localparam logic [c_OCC_W-1:0] c_OCC_FULL = c_OCC_W'(DEPTH);
    localparam logic [c_LEN_W-1:0] c_LEN_MAX  = c_LEN_W'(MAX_BYTES);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RECV  = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;
    localparam logic [1:0] c_ST_ERROR = 2'd3;

    logic [1:0]         r_state;
    logic [c_OCC_W-1:0] r_occupancy;
    logic [c_LEN_W-1:0] r_pkt_len;
    logic               r_rd_valid;

    logic w_full;
    logic w_empty;
    logic w_recv;
    logic w_len_at_max;
    logic w_overflow;
    logic w_len_err;
    logic w_w_en;
    logic w_r_en;

    // Status decodes work on registered occupancy only, so a read in the same
    // cycle never frees a slot for a write.
    assign w_full       = (r_occupancy == c_OCC_FULL);
    assign w_empty      = (r_occupancy == '0);
    assign w_recv       = (r_state == c_ST_RECV);
    assign w_len_at_max = (r_pkt_len == c_LEN_MAX);

    assign w_overflow = bus.byte_ready & w_full;
    assign w_len_err  = bus.byte_ready & w_len_at_max;

    assign w_w_en = w_recv & bus.byte_ready & ~w_full & ~bus.stuff_err & ~w_len_at_max;
    assign w_r_en = bus.rd_req & ~w_empty;

    assign bus.w_en       = w_w_en;
    assign bus.r_en       = w_r_en;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.occupancy  = r_occupancy;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;
    assign bus.pkt_len    = r_pkt_len;
    assign bus.rx_busy    = (r_state == c_ST_RECV);
    assign bus.rx_done    = (r_state == c_ST_DONE);
    assign bus.rx_error   = (r_state == c_ST_ERROR);

    // Packet framing FSM and packet length counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_pkt_len <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.sync_detect) begin
                        r_state   <= c_ST_RECV;
                        r_pkt_len <= '0;
                    end
                end
                c_ST_RECV: begin
                    // Errors take precedence over EOP; a legal byte arriving
                    // with EOP is counted before the packet closes.
                    if (bus.stuff_err || w_overflow || w_len_err) begin
                        r_state <= c_ST_ERROR;
                    end else begin
                        if (w_w_en) begin
                            r_pkt_len <= r_pkt_len + c_LEN_W'(1);
                        end
                        if (bus.eop) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                c_ST_ERROR: begin
                    if (bus.eop) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // FIFO occupancy: simultaneous write and read cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occupancy <= '0;
        end else if (w_w_en && !w_r_en) begin
            r_occupancy <= r_occupancy + c_OCC_W'(1);
        end else if (w_r_en && !w_w_en) begin
            r_occupancy <= r_occupancy - c_OCC_W'(1);
        end
    end

    // Read data appears on the FIFO output the cycle after the read strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_r_en;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_fifo_ctrl
// Description : Self-checking bench for usb_rx_fifo_ctrl. Directed packet
//               scenarios followed by randomized traffic, all compared
//               against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_fifo_ctrl;

    localparam int c_DEPTH = 2;
    localparam int c_MAX   = 4;

    // Model packet phases
    localparam int c_M_IDLE = 0;
    localparam int c_M_RECV = 1;
    localparam int c_M_DONE = 2;
    localparam int c_M_ERR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    usb_rx_fifo_ctrl_if #(.DEPTH(c_DEPTH), .MAX_BYTES(c_MAX)) bus ();

    usb_rx_fifo_ctrl #(.DEPTH(c_DEPTH), .MAX_BYTES(c_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO held as a queue of byte tags, packet as a phase
    int m_phase;
    int m_len;
    int m_rdv;
    int m_q[$];
    int m_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input int ew, input int er);
        int occ;
        occ = m_q.size();
        chk("w_en",       32'(bus.w_en),       32'(ew));
        chk("r_en",       32'(bus.r_en),       32'(er));
        chk("rd_valid",   32'(bus.rd_valid),   32'(m_rdv));
        chk("occupancy",  32'(bus.occupancy),  32'(occ));
        chk("fifo_empty", 32'(bus.fifo_empty), 32'(occ == 0));
        chk("fifo_full",  32'(bus.fifo_full),  32'(occ == c_DEPTH));
        chk("pkt_len",    32'(bus.pkt_len),    32'(m_len));
        chk("rx_busy",    32'(bus.rx_busy),    32'(m_phase == c_M_RECV));
        chk("rx_done",    32'(bus.rx_done),    32'(m_phase == c_M_DONE));
        chk("rx_error",   32'(bus.rx_error),   32'(m_phase == c_M_ERR));
    endtask

    task automatic model_reset();
        m_phase = c_M_IDLE;
        m_len   = 0;
        m_rdv   = 0;
        m_q.delete();
    endtask

    // Asserted between edges so the clear must be asynchronous to show up
    task automatic do_reset();
        bus.sync_detect = 1'b0;
        bus.byte_ready  = 1'b0;
        bus.eop         = 1'b0;
        bus.stuff_err   = 1'b0;
        bus.rd_req      = 1'b0;
        rst = 1'b1;
        model_reset();
        #2;
        check_all(0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: apply inputs, check against model, then advance model
    task automatic cycle(input logic sd, input logic br, input logic e,
                         input logic se, input logic rq);
        int  ew;
        int  er;
        bit  full;
        bus.sync_detect = sd;
        bus.byte_ready  = br;
        bus.eop         = e;
        bus.stuff_err   = se;
        bus.rd_req      = rq;
        #3;
        full = (m_q.size() >= c_DEPTH);
        ew = int'(m_phase == c_M_RECV && br && !se && !full && m_len < c_MAX);
        er = int'(rq && m_q.size() > 0);
        check_all(ew, er);
        if (er != 0) void'(m_q.pop_front());
        if (ew != 0) begin
            m_q.push_back(m_tag);
            m_tag++;
        end
        m_rdv = er;
        case (m_phase)
            c_M_IDLE: if (sd) begin
                m_phase = c_M_RECV;
                m_len   = 0;
            end
            c_M_RECV: begin
                if (se || (br && (full || m_len == c_MAX))) begin
                    m_phase = c_M_ERR;
                end else begin
                    if (ew != 0) m_len++;
                    if (e) m_phase = c_M_DONE;
                end
            end
            c_M_DONE: m_phase = c_M_IDLE;
            default:  if (e) m_phase = c_M_IDLE;
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_tag = 0;
        bus.sync_detect = 1'b0;
        bus.byte_ready  = 1'b0;
        bus.eop         = 1'b0;
        bus.stuff_err   = 1'b0;
        bus.rd_req      = 1'b0;
        #1;
        do_reset();

        // IDLE ignores eop and bytes; no rx_done
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // 1: three bytes with continuous reads, clean eop
        cycle(1, 0, 0, 0, 1);
        repeat (3) cycle(0, 1, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("t1_pkt_len", 32'(bus.pkt_len), 32'd3);
        chk("t1_occ",     32'(bus.occupancy), 32'd0);

        // 2: overflow with no reads, then drain
        cycle(1, 0, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 0, 0);
        chk("t2_error", 32'(bus.rx_error), 32'd1);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // 3: stuff error together with a byte, later bytes ignored
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);

        // 4: over-length packet with continuous reads
        cycle(1, 0, 0, 0, 1);
        repeat (5) cycle(0, 1, 0, 0, 1);
        chk("t4_pkt_len", 32'(bus.pkt_len), 32'd4);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // 5: full FIFO, byte and read together
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        chk("t5_occ", 32'(bus.occupancy), 32'd1);
        cycle(0, 0, 1, 0, 1);

        // 6: reset mid-packet with one byte stored
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        do_reset();
        cycle(0, 0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 9) < 4),
                      ($urandom_range(0, 11) == 0),
                      ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 1) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
